wb_fetch_prefetcher: RTL and testbench
======================================

// Module: wb_fetch_prefetcher
// PURPOSE
//   Wishbone burst-read master that sits directly upstream of the instruction ROM slave.
//   Issues incrementing bursts of BURST_LEN word reads from a sequential fetch address.
//   Buffers returned words, each tagged with its byte address, in a FIFO.
//   Presents them to the CPU fetch stage via valid/ready. flush redirects fetch to a new address.
// PARAMETERS
//   DATA_WIDTH  32  Wishbone data / instruction width
//   ADDR_WIDTH  16  byte address width; words are 4 bytes, adr_o[1:0] always 0
//   BURST_LEN   4   beats per burst, 1..FIFO_DEPTH
//   FIFO_DEPTH  8   entries, power of 2
//   RESET_ADDR  0   first fetch address after reset, word aligned
// PORTS
//   clk_i      in   1           clock, all logic on rising edge
//   rst_n_i    in   1           asynchronous active-low reset
//   adr_o      out  ADDR_WIDTH  Wishbone byte address
//   dat_i      in   DATA_WIDTH  Wishbone read data
//   we_o       out  1           tied 0
//   sel_o      out  4           tied 4'b1111
//   cyc_o      out  1           bus cycle
//   stb_o      out  1           strobe
//   cti_o      out  3           3'b010 incrementing burst, 3'b111 end of burst
//   ack_i      in   1           slave acknowledge
//   flush_i    in   1           discard buffered words and restart fetch
//   flush_addr_i in ADDR_WIDTH  new fetch address; bits [1:0] ignored and forced to 0
//   valid_o    out  1           FIFO head valid
//   data_o     out  DATA_WIDTH  FIFO head word
//   addr_o     out  ADDR_WIDTH  byte address of FIFO head word
//   ready_i    in   1           consumer accepts head; pop occurs when valid_o & ready_i
//   busy_o     out  1           high when FSM is not IDLE
// BEHAVIOUR
// - Reset state (async, rst_n_i low)
//   - cyc_o = stb_o = 0; cti_o = 3'b000; adr_o = RESET_ADDR.
//   - FIFO empty, valid_o = 0, state IDLE.
//   - Reset mid-burst drops cyc_o immediately.
// - FSM states: IDLE, BURST, DISCARD.
//   - IDLE -> BURST when !flush_i and fifo_count <= FIFO_DEPTH-BURST_LEN.
//     Counts pops in the same cycle are not credited. cyc_o/stb_o rise on the next edge.
//   - BURST: cyc_o = stb_o = 1 continuously, no master wait states.
//   - Each edge with ack_i high completes one beat: push {adr_o, dat_i}, adr_o += 4, beat_cnt++.
//   - cti_o = 3'b010 while beat_cnt < BURST_LEN-1, else 3'b111. BURST_LEN==1 uses 3'b111 only.
//   - Ack of the 3'b111 beat: cyc_o, stb_o and cti_o go to 0/0/000 next edge; state -> IDLE.
//   - cyc_o is low for at least one cycle between bursts.
// - Flush
//   - On flush_i: FIFO cleared, valid_o = 0 next cycle, fetch address <= {flush_addr_i[AW-1:2], 2'b00}.
//   - In IDLE: no burst starts that cycle.
//   - In BURST: the burst is never aborted, because the slave holds ack through cti 010.
//     State -> DISCARD; remaining beats complete with the normal cti sequence, data not pushed.
//     The flush-cycle beat itself (ack_i high) is also discarded.
//     After the final beat -> IDLE; the next burst starts at the flush address.
//   - flush_i in DISCARD: the latest flush_addr_i wins.
//   - Flush with a simultaneous pop: flush wins, pop ignored.
// - FIFO
//   - Push and pop in the same cycle are both allowed; count unchanged.
//   - Overflow cannot occur because of the start condition; push when full is an assertion failure.
//   - data_o/addr_o are the registered head; they are held stable while valid_o & !ready_i.
// - Address arithmetic
//   - Modulo 2^ADDR_WIDTH; 0xFFFC + 4 wraps to 0x0000 within a burst.
// - Ack with cyc_o low is ignored.
// TESTING
//   1. Reset, ROM model word[n]=n, ready_i=1.
//      -> cti 010,010,010,111; consumer sees (addr,data) (0,0),(4,1),(8,2),(C,3),(10,4)...
//   2. ready_i=0.
//      -> two bursts fill FIFO to 8; no third cyc_o; raise ready_i, after 4 pops a burst starts at 0x20.
//   3. flush_i with flush_addr_i=0x43 on 2nd ack of a burst.
//      -> beats 3,4 still acked with cti 010,111 and discarded; next burst adr 0x40; first valid addr 0x40.
//   4. flush_i with valid_o & ready_i in the same cycle.
//      -> no pop counted, FIFO empty next cycle, busy_o follows the new burst.
//   5. RESET_ADDR=0xFFF8, ADDR_WIDTH=16.
//      -> burst addresses FFF8,FFFC,0000,0004.
//   6. rst_n_i low for 1 cycle mid-burst.
//      -> cyc_o/stb_o low asynchronously, valid_o=0, next burst at RESET_ADDR.

Source files
------------

// File: rtl/wb_fetch_prefetcher_if.sv
// wb_fetch_prefetcher_if: Wishbone burst-read bus between the fetch prefetcher (master) and instruction ROM (slave)
//   adr, we, sel, cyc, stb, cti : master -> slave
//   dat, ack                    : slave -> master
interface wb_fetch_prefetcher_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0] dat;
   logic                  we;
   logic [3:0]            sel;
   logic                  cyc;
   logic                  stb;
   logic [2:0]            cti;
   logic                  ack;
   modport master (output adr, we, sel, cyc, stb, cti, input dat, ack);
   modport slave (input adr, we, sel, cyc, stb, cti, output dat, ack);
endinterface

// File: rtl/wb_fetch_prefetcher.sv
// wb_fetch_prefetcher: Wishbone burst-read instruction prefetcher with tagged FIFO and flush redirect
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   wb (master)             : Wishbone burst-read bus to the instruction ROM
//   flush_i, flush_addr_i   : drop buffered words and restart fetch at flush_addr_i
//   valid_o, data_o, addr_o : FIFO head word and its byte address
//   ready_i                 : consumer accepts the head word
//   busy_o                  : a burst is in progress
module wb_fetch_prefetcher #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    BURST_LEN  = 4,
   parameter int                    FIFO_DEPTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   wb_fetch_prefetcher_if.master wb,
   input  logic                  flush_i,
   input  logic [ADDR_WIDTH-1:0] flush_addr_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   input  logic                  ready_i,
   output logic                  busy_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST_LEN + 1);
   typedef enum logic [1:0] {IDLE, BURST, DISCARD} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] adr_q, nxt_q, flush_adr;
   logic [BW-1:0]         beat_q;
   logic [PW-1:0]         rd_q, wr_q;
   logic [PW:0]           cnt_q;
   logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
   logic                  beat, last, push, pop, start;
   assign flush_adr = {flush_addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign beat      = wb.cyc & wb.ack;
   assign last      = beat_q == BW'(BURST_LEN - 1);
   assign push      = beat & (state_q == BURST) & !flush_i;
   assign pop       = valid_o & ready_i & !flush_i;
   // same-cycle pops are not credited, so the check uses the registered count
   assign start     = !flush_i & (cnt_q <= (PW+1)'(FIFO_DEPTH - BURST_LEN));
   assign wb.cyc    = state_q != IDLE;
   assign wb.stb    = wb.cyc;
   assign wb.we     = 1'b0;
   assign wb.sel    = 4'b1111;
   assign wb.cti    = !wb.cyc ? 3'b000 : last ? 3'b111 : 3'b010;
   assign wb.adr    = adr_q;
   assign busy_o    = wb.cyc;
   assign valid_o   = cnt_q != '0;
   assign data_o    = data_mem[rd_q];
   assign addr_o    = addr_mem[rd_q];
   always_comb begin
      state_d = (state_q == IDLE) ? (start ? BURST : IDLE) :
                (beat && last)    ? IDLE :
                flush_i           ? DISCARD : state_q;
   end
   // adr_q drives the bus during a burst; a flush mid-burst parks its target in
   // nxt_q so the remaining beats keep their incrementing addresses
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         adr_q   <= RESET_ADDR;
         nxt_q   <= RESET_ADDR;
         beat_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            beat_q <= '0;
            if (flush_i) adr_q <= flush_adr;
         end else begin
            if (flush_i) nxt_q <= flush_adr;
            if (beat) begin
               beat_q <= beat_q + 1'b1;
               adr_q  <= !last                ? adr_q + ADDR_WIDTH'(4) :
                         flush_i              ? flush_adr :
                         (state_q == DISCARD) ? nxt_q : adr_q + ADDR_WIDTH'(4);
            end
         end
         if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_mem[wr_q] <= wb.dat;
         addr_mem[wr_q] <= wb.adr;
      end
   end
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(push && cnt_q == (PW+1)'(FIFO_DEPTH)));
endmodule

// File: tb/tb_wb_fetch_prefetcher.sv
// tb_wb_fetch_prefetcher: directed self-checking bench for wb_fetch_prefetcher with a zero-wait ROM (word[n] = n)
module tb_wb_fetch_prefetcher;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ready = 1'b0;
   logic [15:0] flush_addr = '0;
   logic        valid, busy, valid2, busy2;
   logic [31:0] data, data2;
   logic [15:0] addr, addr2;
   int          checks = 0, failures = 0;
   always #5 clk = ~clk;
   wb_fetch_prefetcher_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) wb ();
   wb_fetch_prefetcher_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) wb2 ();
   assign wb.ack  = wb.cyc & wb.stb;
   assign wb.dat  = 32'(wb.adr[15:2]);
   assign wb2.ack = wb2.cyc & wb2.stb;
   assign wb2.dat = 32'(wb2.adr[15:2]);
   wb_fetch_prefetcher #(.RESET_ADDR(16'h0000)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .wb(wb), .flush_i(flush), .flush_addr_i(flush_addr),
      .valid_o(valid), .data_o(data), .addr_o(addr), .ready_i(ready), .busy_o(busy));
   wb_fetch_prefetcher #(.RESET_ADDR(16'hFFF8)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .wb(wb2), .flush_i(1'b0), .flush_addr_i(16'h0000),
      .valid_o(valid2), .data_o(data2), .addr_o(addr2), .ready_i(1'b1), .busy_o(busy2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      checks++;
      if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || wb.cti !== 3'b000) begin
         failures++;
         $display("FAIL reset_bus cyc=%b stb=%b cti=%b expected 0 0 000", wb.cyc, wb.stb, wb.cti);
      end
      checks++;
      if (wb.adr !== 16'h0000 || wb2.adr !== 16'hFFF8) begin
         failures++;
         $display("FAIL reset_adr adr=%h adr2=%h expected 0000 fff8", wb.adr, wb2.adr);
      end
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid valid=%b busy=%b expected 0 0", valid, busy);
      end
   endtask

   task automatic test_stream();
      int   k = 0, nb = 0;
      logic gap = 1'b0;
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 60 && k < 6; c++) begin
         step();
         if (gap) begin
            checks++;
            if (wb.cyc !== 1'b0) begin
               failures++;
               $display("FAIL stream_gap cyc=%b expected 0", wb.cyc);
            end
         end
         gap = 1'b0;
         if (wb.cyc && wb.ack) begin
            if (nb < 4) begin
               checks++;
               if (wb.cti !== (nb == 3 ? 3'b111 : 3'b010)) begin
                  failures++;
                  $display("FAIL stream_cti beat=%0d cti=%b expected %b", nb, wb.cti, nb == 3 ? 3'b111 : 3'b010);
               end
            end
            nb++;
            gap = wb.cti == 3'b111;
         end
         if (valid && ready) begin
            checks++;
            if (addr !== 16'(4 * k) || data !== 32'(k)) begin
               failures++;
               $display("FAIL stream_word k=%0d addr=%h data=%h expected %h %h", k, addr, data, 16'(4 * k), 32'(k));
            end
            k++;
         end
      end
      checks++;
      if (k != 6) begin
         failures++;
         $display("FAIL stream_timeout words=%0d expected 6", k);
      end
   endtask

   task automatic test_backpressure();
      int   starts = 0;
      logic pc = 1'b0;
      do_reset();
      ready = 1'b0;
      repeat (30) begin
         step();
         if (wb.cyc && !pc) starts++;
         pc = wb.cyc;
      end
      checks++;
      if (starts != 2 || wb.cyc !== 1'b0) begin
         failures++;
         $display("FAIL bp_bursts starts=%0d cyc=%b expected 2 0", starts, wb.cyc);
      end
      checks++;
      if (valid !== 1'b1 || addr !== 16'h0000 || data !== 32'h0) begin
         failures++;
         $display("FAIL bp_head valid=%b addr=%h data=%h expected 1 0000 0", valid, addr, data);
      end
      ready = 1'b1;
      for (int c = 0; c < 20 && !wb.cyc; c++) step();
      checks++;
      if (wb.cyc !== 1'b1 || wb.adr !== 16'h0020 || addr !== 16'h0014) begin
         failures++;
         $display("FAIL bp_restart cyc=%b adr=%h head=%h expected 1 0020 0014", wb.cyc, wb.adr, addr);
      end
   endtask

   task automatic test_flush_burst();
      do_reset();
      ready = 1'b0;
      step();
      step();
      checks++;
      if (!(wb.cyc && wb.ack) || wb.cti !== 3'b010 || wb.adr !== 16'h0004) begin
         failures++;
         $display("FAIL fb_second cyc=%b ack=%b cti=%b adr=%h expected 1 1 010 0004", wb.cyc, wb.ack, wb.cti, wb.adr);
      end
      flush = 1'b1;
      flush_addr = 16'h0043;
      step();
      flush = 1'b0;
      checks++;
      if (valid !== 1'b0 || wb.cyc !== 1'b1 || wb.cti !== 3'b010 || wb.adr !== 16'h0008) begin
         failures++;
         $display("FAIL fb_beat3 valid=%b cyc=%b cti=%b adr=%h expected 0 1 010 0008", valid, wb.cyc, wb.cti, wb.adr);
      end
      step();
      checks++;
      if (valid !== 1'b0 || wb.cyc !== 1'b1 || wb.cti !== 3'b111 || wb.adr !== 16'h000C) begin
         failures++;
         $display("FAIL fb_beat4 valid=%b cyc=%b cti=%b adr=%h expected 0 1 111 000c", valid, wb.cyc, wb.cti, wb.adr);
      end
      step();
      checks++;
      if (wb.cyc !== 1'b0 || valid !== 1'b0 || wb.adr !== 16'h0040) begin
         failures++;
         $display("FAIL fb_idle cyc=%b valid=%b adr=%h expected 0 0 0040", wb.cyc, valid, wb.adr);
      end
      step();
      checks++;
      if (wb.cyc !== 1'b1 || wb.adr !== 16'h0040 || wb.cti !== 3'b010) begin
         failures++;
         $display("FAIL fb_newburst cyc=%b adr=%h cti=%b expected 1 0040 010", wb.cyc, wb.adr, wb.cti);
      end
      for (int c = 0; c < 10 && !valid; c++) step();
      checks++;
      if (valid !== 1'b1 || addr !== 16'h0040 || data !== 32'h10) begin
         failures++;
         $display("FAIL fb_first valid=%b addr=%h data=%h expected 1 0040 10", valid, addr, data);
      end
   endtask

   task automatic test_flush_pop();
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 10 && !valid; c++) step();
      checks++;
      if (valid !== 1'b1 || addr !== 16'h0000) begin
         failures++;
         $display("FAIL fp_setup valid=%b addr=%h expected 1 0000", valid, addr);
      end
      flush = 1'b1;
      flush_addr = 16'h0080;
      step();
      flush = 1'b0;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL fp_cleared valid=%b busy=%b expected 0 1", valid, busy);
      end
      for (int c = 0; c < 10 && busy; c++) step();
      checks++;
      if (busy !== 1'b0 || wb.adr !== 16'h0080 || valid !== 1'b0) begin
         failures++;
         $display("FAIL fp_idle busy=%b adr=%h valid=%b expected 0 0080 0", busy, wb.adr, valid);
      end
      step();
      checks++;
      if (busy !== 1'b1 || wb.adr !== 16'h0080) begin
         failures++;
         $display("FAIL fp_busy busy=%b adr=%h expected 1 0080", busy, wb.adr);
      end
      for (int c = 0; c < 10 && !valid; c++) step();
      checks++;
      if (valid !== 1'b1 || addr !== 16'h0080 || data !== 32'h20) begin
         failures++;
         $display("FAIL fp_first valid=%b addr=%h data=%h expected 1 0080 20", valid, addr, data);
      end
   endtask

   task automatic test_wrap();
      int          nb = 0, k = 0;
      logic [15:0] ea [4];
      ea = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
      do_reset();
      for (int c = 0; c < 40 && (nb < 4 || k < 4); c++) begin
         step();
         if (wb2.cyc && wb2.ack && nb < 4) begin
            checks++;
            if (wb2.adr !== ea[nb]) begin
               failures++;
               $display("FAIL wrap_adr beat=%0d adr=%h expected %h", nb, wb2.adr, ea[nb]);
            end
            nb++;
         end
         if (valid2 && k < 4) begin
            checks++;
            if (addr2 !== ea[k] || data2 !== 32'(ea[k] >> 2)) begin
               failures++;
               $display("FAIL wrap_word k=%0d addr=%h data=%h expected %h %h", k, addr2, data2, ea[k], 32'(ea[k] >> 2));
            end
            k++;
         end
      end
      checks++;
      if (nb != 4 || k != 4) begin
         failures++;
         $display("FAIL wrap_timeout beats=%0d words=%0d expected 4 4", nb, k);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      ready = 1'b1;
      for (int c = 0; c < 10 && !(valid && wb.cyc); c++) step();
      checks++;
      if (valid !== 1'b1 || wb.cyc !== 1'b1) begin
         failures++;
         $display("FAIL ar_setup valid=%b cyc=%b expected 1 1", valid, wb.cyc);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || valid !== 1'b0 || wb.adr !== 16'h0000) begin
         failures++;
         $display("FAIL ar_async cyc=%b stb=%b valid=%b adr=%h expected 0 0 0 0000", wb.cyc, wb.stb, valid, wb.adr);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (wb.cyc !== 1'b1 || wb.adr !== 16'h0000) begin
         failures++;
         $display("FAIL ar_restart cyc=%b adr=%h expected 1 0000", wb.cyc, wb.adr);
      end
      for (int c = 0; c < 10 && !valid; c++) step();
      checks++;
      if (valid !== 1'b1 || addr !== 16'h0000 || data !== 32'h0) begin
         failures++;
         $display("FAIL ar_first valid=%b addr=%h data=%h expected 1 0000 0", valid, addr, data);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_burst();
      test_flush_pop();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
